mlp_stream_core: RTL and testbench
==================================

// Module: mlp_stream_core
// PURPOSE
//  Time-multiplexed two-layer MLP (N_IN sign-magnitude inputs -> N_HID hidden ReLU neurons -> 1 output).
//  - Parametrised successor of the fixed, fully-parallel mlp_98 denoiser core.
//  - Evaluates P layer-1 MACs per cycle instead of all at once.
//  - Weights are loadable at run time; input and output use valid/ready handshakes.
//  - Sits between the pixel-window front end (source) and the denoiser output stage (sink).
// PARAMETERS
//  N_IN   49  input elements per vector (each W_X-bit magnitude + 1 polarity bit)
//  N_HID  20  hidden neurons
//  W_X    4   input magnitude width
//  W_K    4   weight width, two's complement
//  P      7   layer-1 MAC lanes per cycle; C = ceil(N_IN/P) chunks per neuron
//  RELU   1   1: hidden = max(acc,0); 0: hidden = acc (linear, for debug)
//  derived: W_H = W_X+W_K+$clog2(N_IN)+1, W_Y = W_H+W_K+$clog2(N_HID), W_WA = $clog2(N_IN*N_HID+N_HID)
// PORTS
//  clk      in   1           clock, rising edge
//  rstn     in   1           asynchronous active-low reset
//  s_valid  in   1           input vector valid
//  s_ready  out  1           core idle, can accept a vector
//  in_mag   in   N_IN*W_X    element i magnitude at [i*W_X +: W_X]
//  in_pol   in   N_IN        element i sign, 1 = negative
//  wr_en    in   1           weight write strobe
//  wr_addr  in   W_WA        0..N_IN*N_HID-1: k1[j][i] at j*N_IN+i; next N_HID addresses: k2[j]
//  wr_data  in   W_K         signed weight
//  busy     out  1           high in any state other than IDLE
//  m_valid  out  1           result valid
//  m_ready  in   1           sink accepts result
//  out      out  W_Y         signed result y
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, s_ready=1, busy=0, m_valid=0, out=0, all accumulators=0, all weights=0.
//  Arithmetic:
//   - x_i = in_pol[i] ? -in_mag[i] : in_mag[i]
//   - h_j = sum_i x_i*k1[j][i]; hidden_j = RELU ? max(h_j,0) : h_j
//   - y = sum_j hidden_j*k2[j]
//   - Signed full-width math; widths above exclude overflow. No rounding, no saturation.
//  States: IDLE -> L1 -> TAIL -> OUT -> IDLE.
//  Edge numbering: E0 = the accept edge (s_valid && s_ready); E1, E2, ... are the following rising edges.
//  IDLE:
//   - s_ready=1.
//   - At E0, in_mag/in_pol are captured into an internal vector register and y_acc is cleared.
//  L1, edges E1..E(N_HID*C):
//   - Neuron j (0..N_HID-1) processes chunk c (0..C-1) with lanes i = c*P+l.
//   - Lanes with i >= N_IN contribute 0.
//   - After the last chunk of neuron j, h_j is loaded into a hidden register.
//   - At the next edge, hidden_j*k2[j] is added to y_acc, overlapped with the MACs of neuron j+1.
//  TAIL, edge E(N_HID*C+1):
//   - Adds the last neuron's term and loads out. m_valid=1 from this edge.
//   - LAT = N_HID*C+1 = 141 at the defaults.
//  OUT:
//   - m_valid=1; out and m_valid hold stable while m_ready=0.
//   - The edge with m_ready=1 clears m_valid and returns to IDLE.
//   - s_ready rises after that edge; there is no same-cycle turnaround.
//   - out keeps its last value after the handshake.
//  s_ready=0 throughout L1, TAIL and OUT. s_valid is ignored in those states and the input register is not updated.
//  Weight writes:
//   - Performed only in IDLE.
//   - wr_en in any other state is dropped silently.
//   - wr_addr >= N_IN*N_HID+N_HID is ignored.
//   - A write and an accept at the same E0 both take effect; the new weight is used by that computation.
//  Reset mid-operation returns to IDLE at once, drops the pending computation and clears the weights.
// TESTING
//  1 Reset -> s_ready=1, busy=0, m_valid=0, out=0; after reset, with all weights 0, any vector -> out=0.
//  2 k1=+1, k2=+1 everywhere, all mag=15, pol=0 -> out=14700; m_valid first high exactly 141 edges after E0.
//  3 Same weights, all pol=1 -> out=0 with RELU=1; out=-14700 with RELU=0.
//  4 Only k1[0][48]=-8 and k2[0]=-8 nonzero; in[48]: mag=15, pol=1 (all other inputs 0) -> h_0=120, out=-960 (lane padding check).
//  5 Hold m_ready=0 for 10 cycles while pulsing s_valid -> out stable, s_ready=0, no new capture; s_ready=1 one edge after the handshake.
//  6 Write k2[0] at E50 -> ignored, result unchanged. Pulse rstn at E70 -> m_valid never rises; the next vector gives out=0.

Source files
------------

// File: rtl/mlp_stream_core.sv
// mlp_stream_core: time-multiplexed two-layer MLP with run-time loadable weights.
// Layer 1 runs P MAC lanes per cycle over C chunks per hidden neuron; the
// layer-2 product of neuron j is folded into y_acc while neuron j+1 is busy.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | s_ready=1, weight writes allowed, waiting for s_valid
// L1    | layer-1 chunk MACs, neuron j_q chunk c_q; layer-2 overlap
// TAIL  | add last neuron's layer-2 term, load out, raise m_valid
// OUT   | hold out/m_valid until m_ready
module mlp_stream_core #(
    parameter int N_IN  = 49,
    parameter int N_HID = 20,
    parameter int W_X   = 4,
    parameter int W_K   = 4,
    parameter int P     = 7,
    parameter int RELU  = 1,
    localparam int W_H  = W_X + W_K + $clog2(N_IN) + 1,
    localparam int W_Y  = W_H + W_K + $clog2(N_HID),
    localparam int W_WA = $clog2(N_IN * N_HID + N_HID)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_IN*W_X-1:0]     in_mag,
    input  logic [N_IN-1:0]         in_pol,
    input  logic                    wr_en,
    input  logic [W_WA-1:0]         wr_addr,
    input  logic signed [W_K-1:0]   wr_data,
    output logic                    busy,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [W_Y-1:0]   out
);

    localparam int C   = (N_IN + P - 1) / P;
    localparam int W_C = (C > 1) ? $clog2(C) : 1;
    localparam int W_J = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int W_I = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [W_C-1:0] C_LAST = W_C'(C - 1);
    localparam logic [W_J-1:0] J_LAST = W_J'(N_HID - 1);

    typedef enum logic [1:0] {IDLE, L1, TAIL, OUT} state_t;

    state_t                 state_q;
    logic                   s_ready_q;
    logic                   busy_q;
    logic                   m_valid_q;
    logic signed [W_Y-1:0]  out_q;

    logic signed [W_X:0]    x_q  [N_IN];
    logic signed [W_K-1:0]  k1_q [N_HID][N_IN];
    logic signed [W_K-1:0]  k2_q [N_HID];

    logic [W_J-1:0]         j_q;
    logic [W_C-1:0]         c_q;
    logic signed [W_H-1:0]  h_acc_q;
    logic signed [W_H-1:0]  hid_q;
    logic signed [W_Y-1:0]  y_acc_q;

    logic signed [W_H-1:0]  chunk_sum;
    logic signed [W_H-1:0]  h_next;
    logic signed [W_H-1:0]  hid_d;
    logic [W_I-1:0]         lane_idx;
    logic [W_J-1:0]         hid_sel;
    logic signed [W_Y-1:0]  y_term;

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign out     = out_q;

    // Layer-1 chunk sum over P lanes; padding lanes past N_IN add nothing.
    always_comb begin
        chunk_sum = '0;
        lane_idx  = '0;
        for (int l = 0; l < P; l++) begin
            if (int'(c_q) * P + l < N_IN) begin
                lane_idx  = W_I'(int'(c_q) * P + l);
                chunk_sum = chunk_sum + W_H'(x_q[lane_idx] * k1_q[j_q][lane_idx]);
            end
        end
        h_next = h_acc_q + chunk_sum;
        hid_d  = ((RELU != 0) && h_next[W_H-1]) ? '0 : h_next;
    end

    // Layer-2 term: hid_q holds neuron j_q-1 during L1, the last neuron in TAIL.
    always_comb begin
        hid_sel = (state_q == TAIL) ? j_q : j_q - 1'b1;
        y_term  = W_Y'(hid_q * k2_q[hid_sel]);
    end

    // Weight file: writes land only while idle; out-of-range addresses match nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < N_HID; j++) begin
                k2_q[j] <= '0;
                for (int i = 0; i < N_IN; i++) k1_q[j][i] <= '0;
            end
        end else if (state_q == IDLE && wr_en) begin
            for (int j = 0; j < N_HID; j++) begin
                if (wr_addr == W_WA'(N_IN * N_HID + j)) k2_q[j] <= wr_data;
                for (int i = 0; i < N_IN; i++)
                    if (wr_addr == W_WA'(j * N_IN + i)) k1_q[j][i] <= wr_data;
            end
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            out_q     <= '0;
            j_q       <= '0;
            c_q       <= '0;
            h_acc_q   <= '0;
            hid_q     <= '0;
            y_acc_q   <= '0;
            for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        for (int i = 0; i < N_IN; i++)
                            x_q[i] <= in_pol[i] ? -$signed({1'b0, in_mag[i*W_X +: W_X]})
                                                :  $signed({1'b0, in_mag[i*W_X +: W_X]});
                        y_acc_q   <= '0;
                        h_acc_q   <= '0;
                        j_q       <= '0;
                        c_q       <= '0;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= L1;
                    end
                end
                L1: begin
                    if (c_q == '0 && j_q != '0) y_acc_q <= y_acc_q + y_term;
                    if (c_q == C_LAST) begin
                        hid_q   <= hid_d;
                        h_acc_q <= '0;
                        c_q     <= '0;
                        if (j_q == J_LAST) state_q <= TAIL;
                        else               j_q     <= j_q + 1'b1;
                    end else begin
                        h_acc_q <= h_next;
                        c_q     <= c_q + 1'b1;
                    end
                end
                TAIL: begin
                    out_q     <= y_acc_q + y_term;
                    m_valid_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_stream_core.sv
// Directed bench for mlp_stream_core: a ReLU instance and a linear instance share
// all inputs; expected results are hand-computed constants.
module tb_mlp_stream_core;

    logic               clk = 1'b0;
    logic               rstn;
    logic               s_valid;
    logic [195:0]       in_mag;
    logic [48:0]        in_pol;
    logic               wr_en;
    logic [9:0]         wr_addr;
    logic signed [3:0]  wr_data;
    logic               m_ready;

    logic               s_ready, busy, m_valid;
    logic signed [23:0] out;
    logic               s_ready_l, busy_l, m_valid_l;
    logic signed [23:0] out_l;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mlp_stream_core dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .in_mag(in_mag), .in_pol(in_pol), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
        .out(out)
    );

    mlp_stream_core #(.RELU(0)) dut_lin (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_l),
        .in_mag(in_mag), .in_pol(in_pol), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy_l), .m_valid(m_valid_l), .m_ready(m_ready),
        .out(out_l)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0: all 15 positive, 1: all 15 negative, 2: 15 alternating sign,
    // 3: ramp i%16 positive, 4: only element 48 = -15
    task automatic set_in(input int mode);
        for (int i = 0; i < 49; i++) begin
            case (mode)
                0: begin in_mag[i*4 +: 4] = 4'd15; in_pol[i] = 1'b0; end
                1: begin in_mag[i*4 +: 4] = 4'd15; in_pol[i] = 1'b1; end
                2: begin in_mag[i*4 +: 4] = 4'd15; in_pol[i] = (i % 2 == 1); end
                3: begin in_mag[i*4 +: 4] = 4'(i % 16); in_pol[i] = 1'b0; end
                default: begin
                    in_mag[i*4 +: 4] = (i == 48) ? 4'd15 : 4'd0;
                    in_pol[i]        = (i == 48);
                end
            endcase
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[9:0];
        wr_data = d[3:0];
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic start_vec();
        @(negedge clk);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_m_valid_seen"}, m_valid, 1);
        chk({tag, "_lin_m_valid"}, m_valid_l, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input int mode, input int exp_relu, input int exp_lin);
        int lat;
        set_in(mode);
        start_vec();
        wait_result(tag, lat);
        @(negedge clk);
        chk({tag, "_out"}, out, exp_relu);
        chk({tag, "_out_lin"}, out_l, exp_lin);
        ack();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int lat;
        int mv_count;
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_in(0);
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_out", out, 0);
        rstn = 1'b1;

        // zero weights after reset
        run_case("zero_w", 0, 0, 0);

        // all weights +1
        for (int a = 0; a < 1000; a++) wr(a, 1);

        set_in(0);
        start_vec();
        wait_result("ones", lat);
        chk("ones_latency", lat, 141);
        @(negedge clk);
        chk("ones_out", out, 14700);
        chk("ones_out_lin", out_l, 14700);
        chk("ones_busy", busy, 1);
        ack();

        run_case("neg", 1, 0, -14700);
        run_case("alt", 2, 300, 300);
        run_case("ramp", 3, 7200, 7200);

        // single weight pair on the padded last chunk
        pulse_reset();
        wr(48, -8);
        wr(980, -8);
        wr(1000, 7);
        set_in(4);
        start_vec();
        wait_result("pad", lat);
        @(negedge clk);
        chk("pad_out", out, -960);
        chk("pad_out_lin", out_l, -960);

        // hold result with m_ready low while s_valid toggles
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            s_valid = (n % 2 == 0);
            set_in(n % 4);
            @(posedge clk);
            #1;
            chk("hold_out", out, -960);
            chk("hold_s_ready", s_ready, 0);
            chk("hold_m_valid", m_valid, 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("pre_hs_s_ready", s_ready, 0);
        @(posedge clk);
        #1 m_ready = 1'b0;
        chk("post_hs_m_valid", m_valid, 0);
        chk("post_hs_s_ready", s_ready, 1);
        chk("post_hs_out", out, -960);

        // weight write during L1 is dropped
        set_in(4);
        start_vec();
        repeat (49) @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = 10'd980; wr_data = 4'sd7;
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_result("midwr", lat);
        @(negedge clk);
        chk("midwr_out", out, -960);
        ack();

        // reset mid-computation
        set_in(4);
        start_vec();
        repeat (69) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_busy", busy, 0);
        rstn = 1'b1;
        mv_count = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (m_valid) mv_count++;
        end
        chk("midrst_no_m_valid", mv_count, 0);
        run_case("after_rst", 4, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
